// File: rtl/usart_pkg.sv
// Shared types and helpers for the USART receive path.
package usart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_WAIT_HIGH
    } rx_state_t;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    function automatic int clks_per_bit(input int freq, input int baud);
        return freq / baud;
    endfunction

endpackage

// File: rtl/usart_sync_fifo.sv
// Single-clock FIFO with occupancy count; a push into a full FIFO is
// accepted only when a pop frees a slot in the same cycle.
module usart_sync_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 16
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_push,
    input  logic [WIDTH-1:0]       i_din,
    input  logic                   i_pop,
    output logic [WIDTH-1:0]       o_dout,
    output logic                   o_empty,
    output logic                   o_full,
    output logic [$clog2(DEPTH):0] o_count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] CNT_FULL = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == CNT_FULL);
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);
    assign o_count   = r_count;
    // Storage is not reset, so the head is gated to read 0 when empty.
    assign o_dout    = o_empty ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_do_push)
            r_mem[r_wr_ptr] <= i_din;
    end

endmodule

// File: rtl/usart_rx_fifo.sv
// UART receiver with synchroniser, false-start rejection, optional parity,
// 1/2 stop bits and a flagged-word FIFO read out as a valid/ready stream.
module usart_rx_fifo
    import usart_pkg::*;
#(
    parameter int CLK_FREQ   = 100000000,
    parameter int BAUD_RATE  = 115200,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        rx,
    output logic [DATA_BITS-1:0]        m_data,
    output logic                        m_perr,
    output logic                        m_ferr,
    output logic                        m_valid,
    input  logic                        m_ready,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic                        overrun,
    input  logic                        clear_ovr,
    output logic                        busy
);
    localparam int CPB  = clks_per_bit(CLK_FREQ, BAUD_RATE);
    localparam int HALF = CPB / 2;
    localparam int CW   = $clog2(CPB);
    localparam int BW   = $clog2(DATA_BITS + 1);
    localparam int FW   = DATA_BITS + 2;

    localparam bit PAR_EN  = (PARITY == PAR_ODD) || (PARITY == PAR_EVEN);
    localparam bit PAR_EXP = (PARITY == PAR_ODD);

    localparam logic [CW-1:0] CNT_HALF  = CW'(HALF - 1);
    localparam logic [CW-1:0] CNT_LAST  = CW'(CPB - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
    localparam logic          STOP_LAST = (STOP_BITS == 2);

    logic                 r_rx_meta;
    logic                 r_rx_s;
    rx_state_t            r_state;
    rx_state_t            w_state_nxt;
    logic [CW-1:0]        r_clk_cnt;
    logic [BW-1:0]        r_bit_cnt;
    logic                 r_stop_cnt;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_perr;
    logic                 r_ferr;
    logic                 r_overrun;

    logic                 w_tick_half;
    logic                 w_tick_bit;
    logic                 w_sample;
    logic                 w_push;
    logic                 w_ferr_now;
    logic                 w_clr_cnt;
    logic                 w_pop;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_ovr_evt;
    logic [FW-1:0]        w_dout;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rx_s    <= r_rx_meta;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_sample    = 1'b0;
        w_push      = 1'b0;
        w_tick_half = (r_clk_cnt == CNT_HALF);
        w_tick_bit  = (r_clk_cnt == CNT_LAST);
        w_ferr_now  = r_ferr | ~r_rx_s;
        case (r_state)
            ST_IDLE: begin
                if (!r_rx_s)
                    w_state_nxt = ST_START;
            end
            ST_START: begin
                // A line that is high again at mid-start-bit was a glitch.
                if (w_tick_half) begin
                    w_sample    = 1'b1;
                    w_state_nxt = r_rx_s ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (w_tick_bit) begin
                    w_sample = 1'b1;
                    if (r_bit_cnt == BIT_LAST)
                        w_state_nxt = PAR_EN ? ST_PARITY : ST_STOP;
                end
            end
            ST_PARITY: begin
                if (w_tick_bit) begin
                    w_sample    = 1'b1;
                    w_state_nxt = ST_STOP;
                end
            end
            ST_STOP: begin
                // Leaving at mid-stop-bit lets a back-to-back start edge be seen.
                if (w_tick_bit) begin
                    w_sample = 1'b1;
                    if (r_stop_cnt == STOP_LAST) begin
                        w_push      = 1'b1;
                        w_state_nxt = w_ferr_now ? ST_WAIT_HIGH : ST_IDLE;
                    end
                end
            end
            ST_WAIT_HIGH: begin
                if (r_rx_s)
                    w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        w_clr_cnt = w_sample || (w_state_nxt != r_state) ||
                    (r_state == ST_IDLE) || (r_state == ST_WAIT_HIGH);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_clk_cnt  <= '0;
            r_bit_cnt  <= '0;
            r_stop_cnt <= 1'b0;
            r_perr     <= 1'b0;
            r_ferr     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_clk_cnt <= w_clr_cnt ? '0 : r_clk_cnt + 1'b1;
            case (r_state)
                ST_START: begin
                    r_bit_cnt  <= '0;
                    r_stop_cnt <= 1'b0;
                    r_perr     <= 1'b0;
                    r_ferr     <= 1'b0;
                end
                ST_DATA: begin
                    if (w_sample)
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                end
                ST_PARITY: begin
                    if (w_sample)
                        r_perr <= ((^r_shift) ^ r_rx_s) != PAR_EXP;
                end
                ST_STOP: begin
                    if (w_sample) begin
                        r_ferr     <= w_ferr_now;
                        r_stop_cnt <= ~r_stop_cnt;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (r_state == ST_DATA && w_sample)
            r_shift <= {r_rx_s, r_shift[DATA_BITS-1:1]};
    end

    assign m_valid   = ~w_empty;
    assign w_pop     = m_valid & m_ready;
    assign w_ovr_evt = w_push & w_full & ~w_pop;
    assign {m_perr, m_ferr, m_data} = w_dout;

    usart_sync_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (clk),
        .i_rst   (reset),
        .i_push  (w_push),
        .i_din   ({r_perr, w_ferr_now, r_shift}),
        .i_pop   (w_pop),
        .o_dout  (w_dout),
        .o_empty (w_empty),
        .o_full  (w_full),
        .o_count (fifo_count)
    );

    // A drop in the same cycle as a clear wins, so no overrun goes unseen.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_overrun <= 1'b0;
        else if (w_ovr_evt)
            r_overrun <= 1'b1;
        else if (clear_ovr)
            r_overrun <= 1'b0;
    end

    assign overrun = r_overrun;
    assign busy    = (r_state != ST_IDLE);

endmodule

// File: tb/tb_usart_rx_fifo.sv
// Bench for usart_rx_fifo: an 8N1 and an 8E2 instance driven with directed
// and random frames, checked against a queue-based model of received words.
module tb_usart_rx_fifo;

    localparam int CPB   = 16;
    localparam int HALF  = 8;
    localparam int DEPTH = 4;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic       rx_n  = 1'b1;
    logic       rx_e  = 1'b1;
    logic       rdy_n = 1'b0;
    logic       rdy_e = 1'b0;
    logic       clr_n = 1'b0;
    logic       clr_e = 1'b0;
    logic [7:0] data_n, data_e;
    logic       perr_n, perr_e, ferr_n, ferr_e, vld_n, vld_e;
    logic [2:0] cnt_n, cnt_e;
    logic       ovr_n, ovr_e, busy_n, busy_e;

    int n_tests = 0;
    int n_fail  = 0;
    int vcyc_n  = 0;

    logic [9:0] exp_n[$];
    logic [9:0] exp_e[$];
    logic [9:0] got_n[$];
    logic [9:0] got_e[$];
    logic       mov_n = 1'b0;
    logic       mov_e = 1'b0;

    always #5 clk = ~clk;

    usart_rx_fifo #(
        .CLK_FREQ(1600000), .BAUD_RATE(100000), .DATA_BITS(8),
        .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(DEPTH)
    ) u_n (
        .clk(clk), .reset(reset), .rx(rx_n),
        .m_data(data_n), .m_perr(perr_n), .m_ferr(ferr_n), .m_valid(vld_n),
        .m_ready(rdy_n), .fifo_count(cnt_n), .overrun(ovr_n),
        .clear_ovr(clr_n), .busy(busy_n)
    );

    usart_rx_fifo #(
        .CLK_FREQ(1600000), .BAUD_RATE(100000), .DATA_BITS(8),
        .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(DEPTH)
    ) u_e (
        .clk(clk), .reset(reset), .rx(rx_e),
        .m_data(data_e), .m_perr(perr_e), .m_ferr(ferr_e), .m_valid(vld_e),
        .m_ready(rdy_e), .fifo_count(cnt_e), .overrun(ovr_e),
        .clear_ovr(clr_e), .busy(busy_e)
    );

    // Consumer side: every accepted handshake is logged as {perr, ferr, data}.
    always @(negedge clk) begin
        if (vld_n) vcyc_n++;
        if (vld_n && rdy_n) got_n.push_back({perr_n, ferr_n, data_n});
        if (vld_e && rdy_e) got_e.push_back({perr_e, ferr_e, data_e});
    end

    initial begin
        #800000;
        $display("FAIL watchdog: observed no finish, required finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic hold(input int w, input logic b, input int nclk);
        if (w == 0) rx_n = b; else rx_e = b;
        idle(nclk);
    endtask

    // Model: a frame lands in the FIFO unless DEPTH words are already waiting.
    function automatic void model_push(input int w, input logic [9:0] ent);
        if (w == 0) begin
            if (exp_n.size() - got_n.size() >= DEPTH) mov_n = 1'b1;
            else exp_n.push_back(ent);
        end else begin
            if (exp_e.size() - got_e.size() >= DEPTH) mov_e = 1'b1;
            else exp_e.push_back(ent);
        end
    endfunction

    task automatic send_frame(input int w, input logic [7:0] d,
                              input logic par_flip, input logic bad_stop);
        logic pe;
        int   nstop;
        hold(w, 1'b0, CPB);
        for (int i = 0; i < 8; i++) hold(w, d[i], CPB);
        pe = 1'b0;
        if (w == 1) begin
            hold(w, (^d) ^ par_flip, CPB);
            pe = par_flip;
        end
        nstop = (w == 1) ? 2 : 1;
        for (int i = 0; i < nstop; i++) hold(w, ~bad_stop, CPB);
        model_push(w, {pe, bad_stop, d});
    endtask

    task automatic drain_check(input int w, input string tag);
        logic [9:0] g[$];
        logic [9:0] e[$];
        int k;
        if (w == 0) rdy_n = 1'b1; else rdy_e = 1'b1;
        k = 0;
        while (((w == 0) ? vld_n : vld_e) && k < 200) begin
            idle(1);
            k++;
        end
        idle(2);
        check({tag, "_drained"}, 32'((w == 0) ? vld_n : vld_e), 32'd0);
        if (w == 0) begin
            g = got_n; e = exp_n; rdy_n = 1'b0;
            got_n.delete(); exp_n.delete();
        end else begin
            g = got_e; e = exp_e; rdy_e = 1'b0;
            got_e.delete(); exp_e.delete();
        end
        check({tag, "_count"}, 32'(g.size()), 32'(e.size()));
        for (int i = 0; i < e.size() && i < g.size(); i++)
            check($sformatf("%s_entry%0d", tag, i), 32'(g[i]), 32'(e[i]));
    endtask

    initial begin
        logic [7:0] d;
        int         w, nfr, gap;
        logic       pf, bs;

        idle(3);
        check("rst_valid_n", 32'(vld_n), 32'd0);
        check("rst_count_n", 32'(cnt_n), 32'd0);
        check("rst_ovr_n",   32'(ovr_n), 32'd0);
        check("rst_busy_n",  32'(busy_n), 32'd0);
        check("rst_head_n",  32'({perr_n, ferr_n, data_n}), 32'd0);
        check("rst_valid_e", 32'(vld_e), 32'd0);
        check("rst_busy_e",  32'(busy_e), 32'd0);
        check("rst_head_e",  32'({perr_e, ferr_e, data_e}), 32'd0);
        reset = 1'b0;
        idle(4);

        // 8N1 0xA5 with the consumer always ready
        rdy_n = 1'b1;
        vcyc_n = 0;
        send_frame(0, 8'hA5, 1'b0, 1'b0);
        idle(2 * CPB);
        check("a5_valid_cycles", 32'(vcyc_n), 32'd1);
        drain_check(0, "a5");

        // Even parity on 0x03: wrong parity bit, then the correct one
        rdy_e = 1'b1;
        send_frame(1, 8'h03, 1'b1, 1'b0);
        idle(4);
        check("par_bad_seen", 32'(got_e.size()), 32'(exp_e.size()));
        send_frame(1, 8'h03, 1'b0, 1'b0);
        idle(CPB);
        drain_check(1, "par");

        // Bad stop bit followed by a 40-bit-time break
        rdy_n = 1'b1;
        send_frame(0, 8'h3C, 1'b0, 1'b1);
        hold(0, 1'b0, 20 * CPB);
        check("brk_busy_mid", 32'(busy_n), 32'd1);
        hold(0, 1'b0, 20 * CPB);
        check("brk_busy_end", 32'(busy_n), 32'd1);
        check("brk_one_entry", 32'(got_n.size()), 32'(exp_n.size()));
        hold(0, 1'b1, CPB);
        check("brk_released", 32'(busy_n), 32'd0);
        send_frame(0, 8'h5A, 1'b0, 1'b0);
        idle(CPB);
        drain_check(0, "brk");

        // 4-cycle low glitch on an idle line
        hold(0, 1'b0, 4);
        hold(0, 1'b1, 2);
        check("glitch_busy", 32'(busy_n), 32'd1);
        idle(HALF + 1);
        check("glitch_idle", 32'(busy_n), 32'd0);
        check("glitch_count", 32'(cnt_n), 32'd0);
        check("glitch_nopush", 32'(got_n.size()), 32'd0);

        // Overflow: five back-to-back frames into a 4-deep FIFO
        rdy_n = 1'b0;
        for (int v = 1; v <= 5; v++) send_frame(0, 8'(v), 1'b0, 1'b0);
        idle(2);
        check("ovr_count", 32'(cnt_n), 32'(exp_n.size()));
        check("ovr_flag", 32'(ovr_n), 32'(mov_n));
        check("ovr_head", 32'(data_n), 32'h01);
        idle(5);
        check("ovr_head_hold", 32'(data_n), 32'h01);
        drain_check(0, "ovr");
        check("ovr_sticky", 32'(ovr_n), 32'(mov_n));
        clr_n = 1'b1;
        idle(1);
        clr_n = 1'b0;
        mov_n = 1'b0;
        check("ovr_cleared", 32'(ovr_n), 32'(mov_n));

        // Reset in the middle of the data bits of 0x77
        rdy_n = 1'b1;
        hold(0, 1'b0, CPB);
        hold(0, 1'b1, 3 * CPB + 4);
        check("rst_mid_busy", 32'(busy_n), 32'd1);
        reset = 1'b1;
        idle(2);
        reset = 1'b0;
        check("rst_mid_idle", 32'(busy_n), 32'd0);
        check("rst_mid_count", 32'(cnt_n), 32'd0);
        hold(0, 1'b1, 12 * CPB);
        check("rst_mid_nopush", 32'(got_n.size()), 32'd0);
        send_frame(0, 8'h88, 1'b0, 1'b0);
        idle(CPB);
        drain_check(0, "rst");

        // Random bursts on both instances
        for (int r = 0; r < 10; r++) begin
            w = r % 2;
            if (w == 0) rdy_n = 1'($urandom % 2); else rdy_e = 1'($urandom % 2);
            nfr = $urandom_range(1, 4);
            for (int f = 0; f < nfr; f++) begin
                d   = 8'($urandom);
                pf  = (w == 1) && ($urandom % 4 == 0);
                bs  = ($urandom % 6 == 0);
                send_frame(w, d, pf, bs);
                gap = bs ? $urandom_range(1, 3) : $urandom_range(0, 2);
                if (gap > 0) hold(w, 1'b1, gap * CPB);
            end
            idle(CPB);
            check($sformatf("rnd%0d_ovr", r), 32'((w == 0) ? ovr_n : ovr_e),
                  32'((w == 0) ? mov_n : mov_e));
            drain_check(w, $sformatf("rnd%0d", r));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/usart_rx_fifo.md
# usart_rx_fifo

Parametrised UART receiver, the successor to the single-byte receiver in the USART block set. Adds configurable data width, optional parity, 1 or 2 stop bits, input synchronisation and false-start rejection. Received words go into an internal FIFO with per-word error flags, and are read out through a valid/ready stream. It sits between the `rx` pin and any consumer that cannot accept a word on every frame boundary.

## Interface
- `CLK_FREQ`, 100000000: clock frequency in Hz.
- `BAUD_RATE`, 115200: line rate in baud. `CLKS_PER_BIT = CLK_FREQ / BAUD_RATE` must be at least 8.
- `DATA_BITS`, 8: data bits per frame, legal range 5–9.
- `PARITY`, 0: parity mode. 0 = none, 1 = odd, 2 = even.
- `STOP_BITS`, 1: stop bits per frame, 1 or 2.
- `FIFO_DEPTH`, 16: FIFO entries. Must be a power of 2, at least 2.
- `clk`, in, 1: the single clock.
- `reset`, in, 1: asynchronous, active-high reset.
- `rx`, in, 1: serial line. Asynchronous to `clk`; idles high.
- `m_data`, out, DATA_BITS: data word at the FIFO head.
- `m_perr`, out, 1: parity error flag of the head entry. Always 0 when `PARITY` = 0.
- `m_ferr`, out, 1: framing error flag of the head entry.
- `m_valid`, out, 1: FIFO is not empty.
- `m_ready`, in, 1: consumer accepts the head entry.
- `fifo_count`, out, $clog2(FIFO_DEPTH)+1: current occupancy.
- `overrun`, out, 1: sticky flag; a frame was dropped because the FIFO was full.
- `clear_ovr`, in, 1: one-cycle pulse that clears `overrun`.
- `busy`, out, 1: high whenever the receive FSM is not in IDLE.

## Operation
- Synchronisation: `rx` passes through a 2-flop synchroniser, reset value 1. All FSM decisions use the synchronised signal `rx_s`.
- Bit-time counter:
  - `clk_cnt` is $clog2(CLKS_PER_BIT) bits wide.
  - `HALF = CLKS_PER_BIT / 2`.
  - `clk_cnt` clears on every state transition and on every sample.
- FSM states and transitions:
  - IDLE: when `rx_s` = 0, go to START.
  - START: at `clk_cnt` = HALF-1, sample `rx_s`. If 0, go to DATA. If 1, it is a glitch; return to IDLE and push nothing.
  - DATA: at `clk_cnt` = CLKS_PER_BIT-1, sample one bit, shifting in LSB first. After DATA_BITS samples, go to PARITY if `PARITY` ≠ 0, otherwise to STOP.
  - PARITY: sample once at `clk_cnt` = CLKS_PER_BIT-1. `perr` = (XOR of data bits XOR parity bit) ≠ expected. Expected is 1 for odd, 0 for even. Then go to STOP.
  - STOP: sample STOP_BITS times at `clk_cnt` = CLKS_PER_BIT-1. `ferr` is set if any stop sample is 0. After the last sample, push {perr, ferr, data} to the FIFO. Go to IDLE if `ferr` = 0, otherwise to WAIT_HIGH.
  - WAIT_HIGH: stay until `rx_s` = 1, then go to IDLE. This stops a break condition from being re-read as a stream of frames.
- FIFO push:
  - Not full: the entry is written.
  - Full and no pop in the same cycle: the frame is dropped and `overrun` is set.
  - Full with a simultaneous pop: the push is accepted and `overrun` is unchanged.
- FIFO pop occurs when `m_valid && m_ready`. Pop while empty is impossible because `m_valid` = 0.
- `overrun`: if `clear_ovr` and an overrun event occur in the same cycle, `overrun` stays set.
- Reset at any time, including mid-frame: FSM returns to IDLE, FIFO empties, the partial frame is discarded.
- Reset values: `m_valid` = 0, `fifo_count` = 0, `overrun` = 0, `busy` = 0. `m_data`, `m_perr` and `m_ferr` read 0, because storage is cleared or the outputs are gated.

## Timing
- The synchroniser adds 2 cycles from an `rx` edge to `rx_s`.
- Data is sampled HALF + k·CLKS_PER_BIT cycles after the start edge is seen on `rx_s`.
- Push happens in the same cycle as the last stop-bit sample. `m_valid` rises on the next edge.
- Total delay from the start edge on `rx` to `m_valid` is 2 + HALF + (DATA_BITS + P + STOP_BITS)·CLKS_PER_BIT + 1 cycles, where P = 1 if parity is enabled, else 0.
- `m_data`, `m_perr` and `m_ferr` stay stable while `m_valid` is high and `m_ready` is low.
- After a pop, the next entry appears on the next cycle. No bubble when the FIFO holds 2 or more entries.
- The FSM returns to IDLE at mid-stop-bit, so back-to-back frames with no idle gap are received without loss.
- `fifo_count` updates on the cycle after a push or pop; it is unchanged on a simultaneous push and pop.

## Structure
- Package `usart_pkg`:
  - FSM state enum: IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
  - Parity-mode constants: PAR_NONE, PAR_ODD, PAR_EVEN.
  - Function `clks_per_bit(freq, baud)`.
- Sub-module `usart_sync_fifo`:
  - Parameters WIDTH and DEPTH.
  - Asynchronous reset; push/pop with full/empty flags; count output.
  - Instantiated with WIDTH = DATA_BITS + 2.
- Top level: synchroniser, FSM, shift register, parity logic, overrun flag.

## Test plan
All scenarios use CLK_FREQ = 1600000 and BAUD_RATE = 100000, giving CLKS_PER_BIT = 16.
- 8N1 frame 0xA5, `m_ready` held high -> one entry: `m_data` = 0xA5, `m_perr` = 0, `m_ferr` = 0, `m_valid` high for exactly 1 cycle.
- PARITY = 2 (even), frame 0x03 with parity bit 1 -> `m_perr` = 1; the same frame with parity bit 0 -> `m_perr` = 0.
- Stop bit driven 0, then `rx` held low for 40 bit times -> exactly 1 entry with `m_ferr` = 1 and `busy` high until `rx` returns high; a following 0x5A frame is received clean.
- 4-cycle low glitch on idle `rx` -> no push, and `busy` returns to 0 within HALF + 3 cycles.
- FIFO_DEPTH = 4, `m_ready` = 0, frames 0x01–0x05 -> `fifo_count` = 4, `overrun` = 1; reads return 0x01..0x04; `clear_ovr` pulse clears `overrun`.
- `reset` asserted mid-DATA of frame 0x77 and released -> no entry from 0x77; a following frame 0x88 is received correctly.
